// File: rtl/usb_rx_pkg.sv
// Shared types and limits for the USB full-speed NRZI receive front end.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10,
    LINE_SE1 = 2'b11
  } line_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_EOP1  = 3'd3,
    ST_EOP2  = 3'd4,
    ST_ABORT = 3'd5
  } rx_state_t;

  localparam int STUFF_LIMIT  = 6;
  localparam int MAX_PKT_BITS = 99;

  // SYNC is K J K J K J K K: alternating, except the closing K K.
  function automatic line_t sync_expect(input logic [2:0] idx);
    if (idx == 3'd7 || !idx[0]) return LINE_K;
    return LINE_J;
  endfunction

endpackage

// File: rtl/nrzi_bit_dec.sv
// NRZI decoder with bit-stuffing detection; previous line level and run of ones.
module nrzi_bit_dec
  import usb_rx_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  init,
  input  logic  sample,
  input  line_t level,
  output logic  dec_bit,
  output logic  stuffed,
  output logic  stuff_err
);

  localparam logic [2:0] LIMIT = 3'(STUFF_LIMIT);

  line_t      prev_reg;
  logic [2:0] ones_reg;

  // No transition on the line means a 1.
  assign dec_bit   = (level == prev_reg);
  assign stuffed   = (ones_reg == LIMIT) && !dec_bit;
  assign stuff_err = (ones_reg == LIMIT) && dec_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= LINE_SE0;
      ones_reg <= 3'd0;
    end else if (init) begin
      prev_reg <= LINE_K;
      ones_reg <= 3'd0;
    end else if (sample) begin
      prev_reg <= level;
      ones_reg <= (dec_bit && !stuff_err) ? ones_reg + 3'd1 : 3'd0;
    end
  end

endmodule

// File: rtl/nrzi_unstuff_rx.sv
// USB receive path: SYNC detect, NRZI decode, unstuff, EOP/abort framing.
module nrzi_unstuff_rx
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic dp,
  input  logic dm,
  input  logic readyIn,
  output logic bitOut,
  output logic bitOutAvail,
  output logic done,
  output logic rxErr,
  output logic rxActive
);

  localparam logic [6:0] MAX_BITS = 7'(MAX_PKT_BITS);

  line_t      line;
  rx_state_t  state_reg, state_next;
  logic [2:0] sync_idx_reg, sync_idx_next;
  logic [6:0] bit_cnt_reg, bit_cnt_next;
  logic       bit_out_reg, bit_out_next;
  logic       avail_reg, avail_next;
  logic       done_reg, done_next;
  logic       err_reg, err_next;
  logic       active_reg;
  logic       dec_init, dec_sample, dec_bit, stuffed, stuff_err;

  assign line = line_t'({dp, dm});

  nrzi_bit_dec u_dec (
    .clk       (clk),
    .rst       (rst),
    .init      (dec_init),
    .sample    (dec_sample),
    .level     (line),
    .dec_bit   (dec_bit),
    .stuffed   (stuffed),
    .stuff_err (stuff_err)
  );

  always_comb begin
    state_next    = state_reg;
    sync_idx_next = sync_idx_reg;
    bit_cnt_next  = bit_cnt_reg;
    bit_out_next  = bit_out_reg;
    avail_next    = 1'b0;
    done_next     = 1'b0;
    err_next      = 1'b0;
    dec_init      = 1'b0;
    dec_sample    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (line == LINE_K) begin
          state_next    = ST_SYNC;
          sync_idx_next = 3'd1;
        end
      end
      ST_SYNC: begin
        if (line != sync_expect(sync_idx_reg)) begin
          state_next = ST_IDLE;
        end else if (sync_idx_reg == 3'd7) begin
          state_next   = ST_DATA;
          dec_init     = 1'b1;
          bit_cnt_next = 7'd0;
        end else begin
          sync_idx_next = sync_idx_reg + 3'd1;
        end
      end
      ST_DATA: begin
        case (line)
          LINE_J, LINE_K: begin
            dec_sample = 1'b1;
            // Stuffed zeros update the decoder but are never counted or emitted.
            if (stuff_err || (!stuffed && (bit_cnt_reg == MAX_BITS || !readyIn))) begin
              state_next = ST_ABORT;
              done_next  = 1'b1;
              err_next   = 1'b1;
            end else if (!stuffed) begin
              bit_out_next = dec_bit;
              avail_next   = 1'b1;
              bit_cnt_next = bit_cnt_reg + 7'd1;
            end
          end
          LINE_SE0: state_next = ST_EOP1;
          default: begin
            state_next = ST_ABORT;
            done_next  = 1'b1;
            err_next   = 1'b1;
          end
        endcase
      end
      ST_EOP1: begin
        if (line == LINE_SE0) begin
          state_next = ST_EOP2;
        end else begin
          state_next = ST_ABORT;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end
      end
      ST_EOP2: begin
        if (line == LINE_J) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = ST_ABORT;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end
      end
      ST_ABORT: begin
        if (line == LINE_J) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      sync_idx_reg <= 3'd0;
      bit_cnt_reg  <= 7'd0;
      bit_out_reg  <= 1'b0;
      avail_reg    <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      active_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sync_idx_reg <= sync_idx_next;
      bit_cnt_reg  <= bit_cnt_next;
      bit_out_reg  <= bit_out_next;
      avail_reg    <= avail_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      active_reg   <= (state_next == ST_DATA) || (state_next == ST_EOP1) ||
                      (state_next == ST_EOP2);
    end
  end

  assign bitOut      = bit_out_reg;
  assign bitOutAvail = avail_reg;
  assign done        = done_reg;
  assign rxErr       = err_reg;
  assign rxActive    = active_reg;

endmodule

// File: tb/tb_nrzi_unstuff_rx.sv
// Randomised packet bench for nrzi_unstuff_rx with a packet-level expectation model.
module tb_nrzi_unstuff_rx;

  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] L0 = 2'b00;
  localparam logic [1:0] L1 = 2'b11;
  localparam int NCYC = 40000;

  logic clk = 1'b0;
  logic rst, dp, dm, readyIn;
  logic bitOut, bitOutAvail, done, rxErr, rxActive;

  nrzi_unstuff_rx dut (
    .clk         (clk),
    .rst         (rst),
    .dp          (dp),
    .dm          (dm),
    .readyIn     (readyIn),
    .bitOut      (bitOut),
    .bitOutAvail (bitOutAvail),
    .done        (done),
    .rxErr       (rxErr),
    .rxActive    (rxActive)
  );

  always #5 clk = ~clk;

  // Expected outputs indexed by the clock edge that samples the stimulus.
  bit e_vld[NCYC], e_av[NCYC], e_bit[NCYC], e_chkb[NCYC];
  bit e_done[NCYC], e_err[NCYC], e_act[NCYC];
  int edge_cnt = 0;
  int total = 0;
  int bad = 0;

  logic       obs_bits[$];
  int         obs_done = 0;
  int         obs_err = 0;
  bit         data_q[$];
  logic [1:0] enc_q[$];
  logic [1:0] sync_seq[8] = '{LK, LJ, LK, LJ, LK, LJ, LK, LK};

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s edge=%0d got=%b want=%b", nm, edge_cnt - 1, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, a, e);
    end
  endtask

  always @(negedge clk) begin : cmp_blk
    int i;
    i = edge_cnt - 1;
    if (i >= 0 && i < NCYC && e_vld[i]) begin
      chk("bitOutAvail", bitOutAvail, e_av[i]);
      chk("done", done, e_done[i]);
      chk("rxErr", rxErr, e_err[i]);
      chk("rxActive", rxActive, e_act[i]);
      if (e_chkb[i]) chk("bitOut", bitOut, e_bit[i]);
      if (bitOutAvail === 1'b1) obs_bits.push_back(bitOut);
      if (done === 1'b1) obs_done++;
      if (rxErr === 1'b1) obs_err++;
    end
  end

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] flip(input logic [1:0] l);
    return (l == LJ) ? LK : LJ;
  endfunction

  // One bit period: drive inputs and record what the outputs must be after this edge.
  task automatic step(input logic [1:0] ln, input logic rdy, input logic r,
                      input logic av, input logic b, input logic dn,
                      input logic er, input logic act);
    int i;
    i = edge_cnt;
    if (i >= NCYC) begin
      $display("FAIL cycle_budget edge=%0d limit=%0d", i, NCYC);
      $fatal(1, "cycle budget exhausted");
    end
    {dp, dm} = ln;
    readyIn = rdy;
    rst = r;
    e_vld[i] = 1'b1;
    e_av[i] = av;
    e_bit[i] = b;
    e_chkb[i] = av | r;
    e_done[i] = dn;
    e_err[i] = er;
    e_act[i] = act;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(LJ, rnd(), 1'b0, 0, 0, 0, 0, 0);
  endtask

  // After an abort the receiver must stay quiet until the line returns to J.
  task automatic abort_tail();
    step(LK, rnd(), 1'b0, 0, 0, 0, 0, 0);
    step(L0, rnd(), 1'b0, 0, 0, 0, 0, 0);
    idle(3);
  endtask

  // mode: 0 clean EOP, 1 no stuffing by transmitter, 2 readyIn low at emitted bit par,
  //       3 broken EOP, 4 reset at data bit par, 5 SE1 at data bit par.
  task automatic send_packet(input int mode, input int par);
    logic [1:0] lvl, nl;
    int ones, emitted;
    logic b, rdy;
    enc_q.delete();
    idle(2);
    for (int k = 0; k < 8; k++) step(sync_seq[k], rnd(), 1'b0, 0, 0, 0, 0, k == 7);
    lvl = LK;
    ones = 0;
    emitted = 0;
    for (int k = 0; k < data_q.size(); k++) begin
      b = data_q[k];
      nl = b ? lvl : flip(lvl);
      if (mode == 4 && k == par) begin
        step(nl, rnd(), 1'b1, 0, 0, 0, 0, 0);
        idle(3);
        return;
      end
      if (mode == 5 && k == par) begin
        step(L1, rnd(), 1'b0, 0, 0, 1, 1, 0);
        abort_tail();
        return;
      end
      enc_q.push_back(nl);
      lvl = nl;
      if (ones == 6) begin
        // After six ones the receiver treats a 0 as stuffing and a 1 as an error.
        if (b) begin
          step(nl, rnd(), 1'b0, 0, 0, 1, 1, 0);
          abort_tail();
          return;
        end
        step(nl, rnd(), 1'b0, 0, 0, 0, 0, 1);
        ones = 0;
        continue;
      end
      rdy = !(mode == 2 && emitted == par);
      if (emitted == 99 || !rdy) begin
        step(nl, rdy, 1'b0, 0, 0, 1, 1, 0);
        abort_tail();
        return;
      end
      step(nl, 1'b1, 1'b0, 1, b, 0, 0, 1);
      emitted++;
      ones = b ? ones + 1 : 0;
      if (ones == 6 && mode != 1) begin
        lvl = flip(lvl);
        enc_q.push_back(lvl);
        step(lvl, rnd(), 1'b0, 0, 0, 0, 0, 1);
        ones = 0;
      end
    end
    step(L0, rnd(), 1'b0, 0, 0, 0, 0, 1);
    if (mode == 3 && par[0]) begin
      step(LK, rnd(), 1'b0, 0, 0, 1, 1, 0);
      abort_tail();
    end else if (mode == 3) begin
      step(L0, rnd(), 1'b0, 0, 0, 0, 0, 1);
      step(L1, rnd(), 1'b0, 0, 0, 1, 1, 0);
      abort_tail();
    end else begin
      step(L0, rnd(), 1'b0, 0, 0, 0, 0, 1);
      step(LJ, rnd(), 1'b0, 0, 0, 1, 0, 0);
      idle(2);
    end
  endtask

  task automatic clear_obs();
    obs_bits.delete();
    obs_done = 0;
    obs_err = 0;
  endtask

  initial begin : drive
    logic [7:0] pat;
    logic [7:0] got;
    logic [1:0] exp34[8];
    int nb;
    int mode;
    exp34 = '{LJ, LJ, LK, LJ, LJ, LK, LK, LK};

    repeat (3) step(LK, 1'b1, 1'b1, 0, 0, 0, 0, 0);
    idle(3);

    // Clean 8-bit packet 0,1,0,0,1,0,1,1.
    clear_obs();
    pat = 8'b0100_1011;
    data_q.delete();
    for (int i = 0; i < 8; i++) data_q.push_back(pat[7 - i]);
    send_packet(0, 0);
    for (int i = 0; i < 8; i++) chk_int("enc34", int'(enc_q[i]), int'(exp34[i]));
    got = '0;
    for (int i = 0; i < obs_bits.size() && i < 8; i++) got[7 - i] = obs_bits[i];
    chk_int("bits34_count", obs_bits.size(), 8);
    chk_int("bits34_value", int'(got), 8'h4B);
    chk_int("done34", obs_done, 1);
    chk_int("err34", obs_err, 0);

    // Seven ones with transmitter stuffing after the sixth.
    clear_obs();
    data_q.delete();
    repeat (7) data_q.push_back(1'b1);
    send_packet(0, 0);
    chk_int("enc35_len", enc_q.size(), 8);
    chk_int("enc35_stuff", int'(enc_q[6]), int'(LJ));
    chk_int("bits35_count", obs_bits.size(), 7);
    chk_int("bits35_ones", obs_bits.sum() with (int'(item)), 7);
    chk_int("err35", obs_err, 0);

    // Seven ones with no stuffing: abort on the seventh.
    clear_obs();
    send_packet(1, 0);
    chk_int("bits36_count", obs_bits.size(), 6);
    chk_int("done36", obs_done, 1);
    chk_int("err36", obs_err, 1);

    // 100 data bits: the last one overflows the packet limit.
    clear_obs();
    data_q.delete();
    repeat (100) data_q.push_back(bit'($urandom_range(0, 1)));
    send_packet(0, 0);
    chk_int("bits37_count", obs_bits.size(), 99);
    chk_int("err37", obs_err, 1);

    // readyIn low on the fifth bit.
    clear_obs();
    send_packet(2, 4);
    chk_int("bits37r_count", obs_bits.size(), 4);
    chk_int("err37r", obs_err, 1);

    // Broken SYNC: K J K J K J J.
    clear_obs();
    for (int k = 0; k < 6; k++) step(sync_seq[k], 1'b1, 1'b0, 0, 0, 0, 0, 0);
    idle(4);
    chk_int("sync_fail_bits", obs_bits.size(), 0);
    chk_int("sync_fail_done", obs_done, 0);

    // Reset at bit 20 of a packet.
    clear_obs();
    data_q.delete();
    repeat (30) data_q.push_back(bit'($urandom_range(0, 1)));
    send_packet(4, 20);
    chk_int("rst_mid_done", obs_done, 0);

    for (int p = 0; p < 150; p++) begin
      nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(95, 105)) : int'($urandom_range(0, 30));
      data_q.delete();
      for (int i = 0; i < nb; i++) data_q.push_back(bit'($urandom_range(0, 3) != 0));
      mode = $urandom_range(0, 5);
      send_packet(mode, $urandom_range(0, (nb > 0) ? nb : 1));
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
